// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the transmit-side buffer and its bench.
package uart_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned OVERSAMPLE = 16;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2
  } tx_buf_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count and a one-cycle overflow pulse on dropped pushes.
module uart_sync_fifo #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data_c,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok_c;
  logic             push_ok_c;

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign pop_data_c = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  always_comb begin
    pop_ok_c   = pop && !empty;
    push_ok_c  = push && (!full || pop_ok_c);
    overflow_d = push && !push_ok_c;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; only slots behind the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus feeder FSM that hands one frame at a time to uart_transmitter.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  input  logic          enable,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    Tx_DATA,
  output logic          Tx_WR,
  input  logic          TX_BUSY
);

  tx_buf_state_t state_q, state_d;
  byte_t         tx_data_q, tx_data_d;
  logic          tx_wr_q, tx_wr_d;
  logic          pop_c;
  logic          start_c;
  byte_t         head_c;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push       (wr_en),
    .push_data  (wr_data),
    .pop        (pop_c),
    .pop_data_c (head_c),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow)
  );

  assign Tx_DATA = tx_data_q;
  assign Tx_WR   = tx_wr_q;
  assign start_c = enable && !empty && !TX_BUSY;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_data_q <= 8'h00;
      tx_wr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_c)  state_d = REQ;
      REQ:       if (TX_BUSY)  state_d = WAIT_DONE;
      WAIT_DONE: if (!TX_BUSY) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Tx_DATA only moves on a pop, so it keeps showing the last byte between frames.
  always_comb begin
    tx_wr_d   = tx_wr_q;
    tx_data_d = tx_data_q;
    pop_c     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_wr_d = 1'b0;
        if (start_c) begin
          pop_c     = 1'b1;
          tx_data_d = head_c;
          tx_wr_d   = 1'b1;
        end
      end
      REQ:       if (TX_BUSY) tx_wr_d = 1'b0;
      WAIT_DONE: tx_wr_d = 1'b0;
      default:   tx_wr_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomised bench for uart_tx_buffer against a queue-based model and a simple transmitter model.
module tb_uart_tx_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_en = 1'b0;
  logic          enable = 1'b0;
  logic          full, empty, overflow, Tx_WR;
  logic [AW:0]   count;
  logic [7:0]    Tx_DATA;
  logic          TX_BUSY;
  logic          xmit_busy = 1'b0;
  logic          ext_busy = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  assign TX_BUSY = xmit_busy | ext_busy;

  always #5 clk = ~clk;

  uart_tx_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .enable   (enable),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .Tx_DATA  (Tx_DATA),
    .Tx_WR    (Tx_WR),
    .TX_BUSY  (TX_BUSY)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Transmitter model: busy rises a few cycles after it sees Tx_WR and stays up for a frame.
  int xm_dly = 0, xm_len = 0;
  int cfg_dly = 2, cfg_len = 20;
  bit cfg_rand = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      xm_dly = 0; xm_len = 0; xmit_busy = 1'b0;
    end else if (xm_len > 0) begin
      xm_len--;
      if (xm_len == 0) xmit_busy = 1'b0;
    end else if (xm_dly > 0) begin
      xm_dly--;
      if (xm_dly == 0) begin
        xmit_busy = 1'b1;
        xm_len = cfg_rand ? int'($urandom_range(8, 1)) : cfg_len;
      end
    end else if (Tx_WR === 1'b1) begin
      xm_dly = cfg_rand ? int'($urandom_range(3, 1)) : cfg_dly;
    end
  end

  // Reference model: a byte queue; a frame start is a pop, accepted writes are pushes.
  int         occ = 0;
  int         frames = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_data = 8'h00;
  logic       prev_wr = 1'b0;

  always @(posedge clk) begin
    logic       we_s, en_s, bz_s, pop_now, acc;
    logic [7:0] wd_s, e;
    int         occ_pre;
    we_s = wr_en; wd_s = wr_data; en_s = enable; bz_s = TX_BUSY;
    #1;
    if (!reset) begin
      occ = 0; exp_q.delete(); last_data = 8'h00; prev_wr = 1'b0;
    end else begin
      occ_pre = occ;
      pop_now = Tx_WR && !prev_wr;
      if (prev_wr) check(bz_s ? "wr_drop" : "wr_hold", 32'(Tx_WR), 32'(!bz_s));
      if (pop_now) begin
        check("pop_gate", 32'(en_s && !bz_s), 32'd1);
        check("pop_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tx_data", 32'(Tx_DATA), 32'(e));
          last_data = e;
          occ--;
        end
        frames++;
      end else begin
        check("tx_data_hold", 32'(Tx_DATA), 32'(last_data));
      end
      acc = we_s && (occ_pre < int'(DEPTH) || pop_now);
      if (acc) begin
        exp_q.push_back(wd_s);
        occ++;
      end
      check("overflow", 32'(overflow), 32'(we_s && !acc));
      check("count", 32'(count), 32'(occ));
      check("full", 32'(full), 32'(occ == int'(DEPTH)));
      check("empty", 32'(empty), 32'(occ == 0));
      prev_wr = Tx_WR;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    enable = 1'b1;
    while (!(occ == 0 && !Tx_WR && !TX_BUSY) && t < 3000) begin
      @(negedge clk); t++;
    end
    check("drain_idle", 32'({occ != 0, Tx_WR, TX_BUSY}), 32'd0);
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, t;
    #1 reset = 1'b0;
    tick(2);
    check("rst_tx_wr", 32'(Tx_WR), 32'd0);
    check("rst_tx_data", 32'(Tx_DATA), 32'h00);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b1;
    tick(1);

    // Single byte with exact latency
    f0 = frames; enable = 1'b1;
    write(8'hDD);
    tick(1);
    check("single_wr", 32'(Tx_WR), 32'd1);
    check("single_data", 32'(Tx_DATA), 32'hDD);
    check("single_empty", 32'(empty), 32'd1);
    drain();
    check("single_frames", 32'(frames - f0), 32'd1);

    // Burst order
    f0 = frames;
    for (int i = 1; i <= 5; i++) write(8'(i));
    drain();
    check("burst_frames", 32'(frames - f0), 32'd5);

    // Fill, overflow, then push+pop at full
    f0 = frames; enable = 1'b0;
    for (int i = 0; i < 16; i++) write(8'h40 + 8'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    write(8'hEE);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    tick(1);
    check("ovf_clear", 32'(overflow), 32'd0);
    enable = 1'b1;
    write(8'h77);
    check("pp_count", 32'(count), 32'd16);
    check("pp_ovf", 32'(overflow), 32'd0);
    check("pp_wr", 32'(Tx_WR), 32'd1);
    drain();
    check("fill_frames", 32'(frames - f0), 32'd17);

    // Enable dropped during a frame
    f0 = frames;
    write(8'hC1); write(8'hC2); write(8'hC3);
    t = 0;
    while (!(TX_BUSY && !Tx_WR) && t < 50) begin tick(1); t++; end
    check("reach_wait", 32'(TX_BUSY && !Tx_WR), 32'd1);
    enable = 1'b0;
    t = 0;
    while (TX_BUSY && t < 50) begin tick(1); t++; end
    tick(10);
    check("en_drop_frames", 32'(frames - f0), 32'd1);
    check("en_drop_count", 32'(count), 32'd2);
    check("en_drop_wr", 32'(Tx_WR), 32'd0);
    drain();
    check("en_resume_frames", 32'(frames - f0), 32'd3);

    // Transmitter busy from outside while idle
    f0 = frames; ext_busy = 1'b1;
    write(8'hB7);
    tick(8);
    check("ext_busy_frames", 32'(frames - f0), 32'd0);
    check("ext_busy_count", 32'(count), 32'd1);
    ext_busy = 1'b0;
    drain();
    check("ext_busy_sent", 32'(frames - f0), 32'd1);

    // Asynchronous reset while a request is pending
    cfg_dly = 12;
    for (int i = 0; i < 5; i++) write(8'hF0 + 8'(i));
    check("pre_rst_wr", 32'(Tx_WR), 32'd1);
    check("pre_rst_count", 32'(count), 32'd4);
    #2 reset = 1'b0;
    #1;
    check("arst_wr", 32'(Tx_WR), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_count", 32'(count), 32'd0);
    tick(2);
    reset = 1'b1;
    cfg_dly = 2;
    f0 = frames;
    write(8'hA5);
    drain();
    check("post_rst_frames", 32'(frames - f0), 32'd1);

    // Random traffic, including writes into a full FIFO
    cfg_rand = 1'b1;
    for (int i = 0; i < 600; i++) begin
      enable  = ($urandom % 4) != 0;
      wr_en   = ($urandom % 2) != 0;
      wr_data = 8'($urandom);
      @(negedge clk);
    end
    wr_en = 1'b0;
    drain();
    cfg_rand = 1'b0;
    check("rand_all_sent", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
